// File: rtl/poly_tone_gen_pkg.sv
// Shared types and constants for the polyphonic tone generator.
// The command struct carries 32-bit fields; instances use the low PER_W/DUR_W bits.
package poly_tone_gen_pkg;

  localparam int MAX_CHANNELS     = 8;
  localparam int DEF_TICKS_PER_MS = 10;
  localparam int CH_W             = 3;
  localparam int CMD_PER_W        = 32;
  localparam int CMD_DUR_W        = 32;

  typedef struct packed {
    logic [CH_W-1:0]      ch;
    logic [CMD_PER_W-1:0] period;
    logic [CMD_DUR_W-1:0] dur;
  } note_cmd_t;

  function automatic int mix_width(input int channels);
    return $clog2(channels + 1);
  endfunction

endpackage

// File: rtl/tone_voice.sv
// One square-wave voice: phase counter with toggle, millisecond duration
// countdown, busy flag and a one-cycle done pulse on natural expiry.
module tone_voice
  import poly_tone_gen_pkg::*;
#(
  parameter int PER_W = 16,
  parameter int DUR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [PER_W-1:0] period,
  input  logic [DUR_W-1:0] dur,
  input  logic             ms_tick,
  output logic             sound,
  output logic             busy,
  output logic             done
);

  logic [PER_W-1:0] phase;
  logic [PER_W-1:0] period_q;
  logic [DUR_W-1:0] dur_cnt;
  logic             expire;
  logic             wrap;

  // dur_cnt of 0 never matches, so sustained notes cannot expire
  assign expire = ms_tick && (dur_cnt == DUR_W'(1));
  assign wrap   = (phase == period_q - PER_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase    <= '0;
      period_q <= '0;
      dur_cnt  <= '0;
      sound    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        // A load outranks expiry on the same edge, so a retrigger never reports done
        phase    <= '0;
        period_q <= period;
        dur_cnt  <= dur;
        sound    <= 1'b0;
        busy     <= (period != '0);
      end else if (busy) begin
        if (ms_tick && (dur_cnt != '0)) begin
          dur_cnt <= dur_cnt - DUR_W'(1);
        end
        if (expire) begin
          phase <= '0;
          sound <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b1;
        end else if (wrap) begin
          phase <= '0;
          sound <= ~sound;
        end else begin
          phase <= phase + PER_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/poly_tone_gen.sv
// Polyphonic square-wave generator: command decode, shared ms prescaler,
// CHANNELS voices and a first-order sigma-delta mix for a single speaker pin.
module poly_tone_gen
  import poly_tone_gen_pkg::*;
#(
  parameter int CHANNELS     = 2,
  parameter int PER_W        = 16,
  parameter int DUR_W        = 8,
  parameter int TICKS_PER_MS = DEF_TICKS_PER_MS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                note_valid,
  output logic                note_ready,
  input  logic [2:0]          note_ch,
  input  logic [PER_W-1:0]    note_period,
  input  logic [DUR_W-1:0]    note_dur,
  output logic [CHANNELS-1:0] sound,
  output logic                sound_mix,
  output logic [CHANNELS-1:0] busy,
  output logic [CHANNELS-1:0] done,
  output logic                cmd_err
);

  localparam int MW   = mix_width(CHANNELS);
  localparam int PS_W = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam logic [MW:0] MIX_FULL = (MW+1)'(CHANNELS);

  note_cmd_t           cmd;
  logic                unused_cmd;
  logic                accept;
  logic                ch_ok;
  logic                ms_tick;
  logic [PS_W-1:0]     presc;
  logic [CHANNELS-1:0] load;
  logic [MW-1:0]       pop_n;
  logic [MW:0]         mix_sum;
  logic [MW:0]         mix_acc_p1;
  logic                mix_next;

  function automatic logic mix_over(input logic [MW:0] s);
    return (s >= MIX_FULL);
  endfunction

  assign cmd = '{ch: note_ch, period: CMD_PER_W'(note_period), dur: CMD_DUR_W'(note_dur)};
  assign unused_cmd = (^(cmd.period >> PER_W)) ^ (^(cmd.dur >> DUR_W));

  assign accept  = note_valid & note_ready;
  assign ch_ok   = ({1'b0, cmd.ch} < 4'(CHANNELS));
  assign ms_tick = (presc == PS_W'(TICKS_PER_MS - 1));

  // Prescaler free-runs; commands never realign it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      note_ready <= 1'b0;
      cmd_err    <= 1'b0;
      presc      <= '0;
    end else begin
      note_ready <= 1'b1;
      cmd_err    <= accept & ~ch_ok;
      presc      <= ms_tick ? '0 : presc + PS_W'(1);
    end
  end

  always_comb begin
    load = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      load[i] = accept && ch_ok && (cmd.ch == CH_W'(i));
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_voice
    tone_voice #(
      .PER_W (PER_W),
      .DUR_W (DUR_W)
    ) u_voice (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (load[g]),
      .period  (cmd.period[PER_W-1:0]),
      .dur     (cmd.dur[DUR_W-1:0]),
      .ms_tick (ms_tick),
      .sound   (sound[g]),
      .busy    (busy[g]),
      .done    (done[g])
    );
  end

  always_comb begin
    pop_n = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      pop_n = pop_n + MW'(sound[i]);
    end
    mix_sum  = mix_acc_p1 + (MW+1)'(pop_n);
    mix_next = mix_over(mix_sum);
  end

  // Mixer stage p1: residue stays below CHANNELS, so MW+1 bits never overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mix_acc_p1 <= '0;
      sound_mix  <= 1'b0;
    end else begin
      mix_acc_p1 <= mix_sum - (mix_next ? MIX_FULL : '0);
      sound_mix  <= mix_next;
    end
  end

endmodule

// File: tb/tb_poly_tone_gen.sv
// Scoreboard bench for poly_tone_gen: stimulus queues timed level checks and
// expected done/cmd_err pulses; a negedge monitor consumes and compares them.
module tb_poly_tone_gen;

  localparam int K_SOUND = 0;
  localparam int K_BUSY  = 1;
  localparam int K_MIX   = 2;
  localparam int K_READY = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        note_valid;
  logic        note_ready;
  logic [2:0]  note_ch;
  logic [15:0] note_period;
  logic [7:0]  note_dur;
  logic [1:0]  sound;
  logic        sound_mix;
  logic [1:0]  busy;
  logic [1:0]  done;
  logic        cmd_err;

  poly_tone_gen #(
    .CHANNELS     (2),
    .PER_W        (16),
    .DUR_W        (8),
    .TICKS_PER_MS (10)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .note_valid  (note_valid),
    .note_ready  (note_ready),
    .note_ch     (note_ch),
    .note_period (note_period),
    .note_dur    (note_dur),
    .sound       (sound),
    .sound_mix   (sound_mix),
    .busy        (busy),
    .done        (done),
    .cmd_err     (cmd_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;
  int rel   = 0;

  typedef struct {
    int         at;
    int         kind;
    logic [7:0] mask;
    logic [7:0] exp;
  } lvl_t;

  typedef struct {
    int         at;
    logic [1:0] done;
    logic       err;
  } pls_t;

  lvl_t lq[$];
  pls_t pq[$];

  function automatic logic [7:0] sample(input int kind);
    case (kind)
      K_SOUND: return 8'(sound);
      K_BUSY:  return 8'(busy);
      K_MIX:   return 8'(sound_mix);
      default: return 8'(note_ready);
    endcase
  endfunction

  function automatic string kname(input int kind);
    case (kind)
      K_SOUND: return "sound";
      K_BUSY:  return "busy";
      K_MIX:   return "sound_mix";
      default: return "note_ready";
    endcase
  endfunction

  function automatic int next_tick(input int after);
    int e = after + 1;
    while ((e - rel) % 10 != 0) e++;
    return e;
  endfunction

  task automatic lvl(input int at, input int kind, input logic [7:0] mask, input logic [7:0] exp);
    lvl_t item;
    item.at = at; item.kind = kind; item.mask = mask; item.exp = exp;
    lq.push_back(item);
  endtask

  task automatic pulse(input int at, input logic [1:0] d, input logic e);
    pls_t item;
    item.at = at; item.done = d; item.err = e;
    pq.push_back(item);
  endtask

  task automatic send(input logic [2:0] ch, input logic [15:0] per, input logic [7:0] dur);
    note_valid  = 1'b1;
    note_ch     = ch;
    note_period = per;
    note_dur    = dur;
    @(negedge clk);
    note_valid  = 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: level checks due this cycle, then any pulse the DUT presents
  always @(negedge clk) begin
    logic [7:0] v;
    int hit;
    for (int i = lq.size() - 1; i >= 0; i--) begin
      if (lq[i].at <= cyc) begin
        v = sample(lq[i].kind) & lq[i].mask;
        n_vec++;
        if (lq[i].at < cyc || v != (lq[i].exp & lq[i].mask)) begin
          n_err++;
          $display("FAIL %s @cyc %0d: got %h, required %h", kname(lq[i].kind), lq[i].at, v,
                   lq[i].exp & lq[i].mask);
        end
        lq.delete(i);
      end
    end
    for (int i = pq.size() - 1; i >= 0; i--) begin
      if (pq[i].at < cyc) begin
        n_vec++;
        n_err++;
        $display("FAIL pulse @cyc %0d: got none, required done=%b cmd_err=%b", pq[i].at, pq[i].done, pq[i].err);
        pq.delete(i);
      end
    end
    if (done != 2'b00 || cmd_err) begin
      hit = -1;
      for (int i = 0; i < pq.size(); i++) if (pq[i].at == cyc) hit = i;
      n_vec++;
      if (hit < 0) begin
        n_err++;
        $display("FAIL pulse @cyc %0d: got done=%b cmd_err=%b, required no pulse", cyc, done, cmd_err);
      end else begin
        if (pq[hit].done != done || pq[hit].err != cmd_err) begin
          n_err++;
          $display("FAIL pulse @cyc %0d: got done=%b cmd_err=%b, required done=%b cmd_err=%b",
                   cyc, done, cmd_err, pq[hit].done, pq[hit].err);
        end
        pq.delete(hit);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, required finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k, e1, e2, s, c0;
    logic [2:0] bad_ch [3];
    rst_n       = 1'b1;
    note_valid  = 1'b0;
    note_ch     = '0;
    note_period = '0;
    note_dur    = '0;
    #1 rst_n = 1'b0;

    // Reset state
    @(negedge clk);
    lvl(cyc + 1, K_SOUND, 8'hff, 8'h00);
    lvl(cyc + 1, K_BUSY,  8'hff, 8'h00);
    lvl(cyc + 1, K_MIX,   8'hff, 8'h00);
    lvl(cyc + 1, K_READY, 8'hff, 8'h00);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rel   = cyc;
    lvl(rel + 1, K_READY, 8'h01, 8'h01);
    lvl(rel + 1, K_BUSY,  8'hff, 8'h00);
    @(negedge clk);

    // Invalid channels, including the first out-of-range index
    bad_ch = '{3'd5, 3'd2, 3'd7};
    foreach (bad_ch[i]) begin
      k = cyc + 1;
      pulse(k, 2'b00, 1'b1);
      lvl(k, K_BUSY, 8'h03, 8'h00);
      send(bad_ch[i], 16'd3, 8'd1);
      @(negedge clk);
    end

    // Single timed note: period 3, 2 ms
    k  = cyc + 1;
    e1 = next_tick(k);
    e2 = e1 + 10;
    for (int c = k; c < e2; c++) begin
      lvl(c, K_SOUND, 8'h01, (((c - k) / 3) % 2 == 1) ? 8'h01 : 8'h00);
      lvl(c, K_BUSY,  8'h01, 8'h01);
    end
    lvl(e2, K_SOUND, 8'h01, 8'h00);
    lvl(e2, K_BUSY,  8'h01, 8'h00);
    pulse(e2, 2'b01, 1'b0);
    send(3'd0, 16'd3, 8'd2);
    wait_until(e2 + 3);

    // Sustained note on voice 1, then stop
    k = cyc + 1;
    for (int c = k; c <= k + 500; c++) begin
      lvl(c, K_SOUND, 8'h02, (((c - k) / 5) % 2 == 1) ? 8'h02 : 8'h00);
      if ((c - k) % 50 == 0) lvl(c, K_BUSY, 8'h02, 8'h02);
    end
    send(3'd1, 16'd5, 8'd0);
    wait_until(k + 500);
    s = cyc + 1;
    lvl(s, K_SOUND, 8'h02, 8'h00);
    lvl(s, K_BUSY,  8'h02, 8'h00);
    send(3'd1, 16'd0, 8'd0);
    repeat (3) @(negedge clk);

    // Retrigger on the expiry edge of a 1 ms note
    while (next_tick(cyc + 1) - (cyc + 1) != 6) @(negedge clk);
    k  = cyc + 1;
    e1 = k + 6;
    for (int c = k; c < e1; c++) lvl(c, K_SOUND, 8'h01, (c - k >= 4) ? 8'h01 : 8'h00);
    for (int c = e1; c < e1 + 8; c++) lvl(c, K_SOUND, 8'h01, (c - e1 >= 4) ? 8'h01 : 8'h00);
    lvl(e1,     K_BUSY, 8'h01, 8'h01);
    lvl(e1 + 7, K_BUSY, 8'h01, 8'h01);
    send(3'd0, 16'd4, 8'd1);
    wait_until(e1 - 1);
    send(3'd0, 16'd4, 8'd0);
    wait_until(e1 + 8);
    s = cyc + 1;
    lvl(s, K_BUSY, 8'h01, 8'h00);
    send(3'd0, 16'd0, 8'd0);
    repeat (2) @(negedge clk);

    // Asynchronous reset between edges during active notes
    send(3'd0, 16'd3, 8'd2);
    send(3'd1, 16'd2, 8'd0);
    repeat (3) @(negedge clk);
    c0 = cyc;
    lvl(c0 + 1, K_BUSY,  8'h03, 8'h03);
    lvl(c0 + 2, K_SOUND, 8'hff, 8'h00);
    lvl(c0 + 2, K_BUSY,  8'hff, 8'h00);
    lvl(c0 + 2, K_MIX,   8'hff, 8'h00);
    lvl(c0 + 2, K_READY, 8'hff, 8'h00);
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    rel   = cyc;
    lvl(rel + 1,  K_READY, 8'h01, 8'h01);
    lvl(rel + 25, K_BUSY,  8'h03, 8'h00);
    wait_until(rel + 30);

    // Mixer: complementary period-1 voices give n = 1 and a 50% stream
    k = cyc + 1;
    lvl(k,     K_SOUND, 8'h03, 8'h00);
    lvl(k,     K_MIX,   8'h01, 8'h00);
    lvl(k + 1, K_MIX,   8'h01, 8'h00);
    for (int c = k + 1; c <= k + 40; c++) begin
      lvl(c, K_SOUND, 8'h03, ((c - k) % 2 == 1) ? 8'h01 : 8'h02);
      if (c >= k + 2) lvl(c, K_MIX, 8'h01, ((c - k) % 2 == 1) ? 8'h01 : 8'h00);
    end
    send(3'd0, 16'd1, 8'd0);
    send(3'd1, 16'd1, 8'd0);
    wait_until(k + 40);
    s = cyc + 1;
    lvl(s + 1, K_BUSY, 8'h03, 8'h00);
    send(3'd0, 16'd0, 8'd0);
    send(3'd1, 16'd0, 8'd0);
    repeat (4) @(negedge clk);

    foreach (lq[i]) begin
      n_vec++;
      n_err++;
      $display("FAIL %s @cyc %0d: got unchecked, required %h", kname(lq[i].kind), lq[i].at, lq[i].exp);
    end
    foreach (pq[i]) begin
      n_vec++;
      n_err++;
      $display("FAIL pulse @cyc %0d: got none, required done=%b cmd_err=%b", pq[i].at, pq[i].done, pq[i].err);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/poly_tone_gen.md
# poly_tone_gen

Parametrised polyphonic tone generator. It replaces the single-voice square-wave path that drives the speaker pin. It accepts timed note commands over a valid/ready port and runs CHANNELS independent square-wave voices, each with a programmable half-period and a millisecond duration. It outputs the per-voice waves plus a one-bit sigma-delta mix for a single speaker pin.

## Interface
Parameters:
- CHANNELS, 2: number of voices (1..8).
- PER_W, 16: half-period field width, in clk cycles.
- DUR_W, 8: duration field width, in ms.
- TICKS_PER_MS, 10: clk cycles per millisecond (≥1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- note_valid  in  1  command present.
- note_ready  out  1  command can be accepted.
- note_ch  in  3  target voice.
- note_period  in  PER_W  half-period in cycles; 0 = stop voice.
- note_dur  in  DUR_W  duration in ms; 0 = sustain until stopped.
- sound  out  CHANNELS  per-voice square waves.
- sound_mix  out  1  sigma-delta mix of `sound`.
- busy  out  CHANNELS  voice active.
- done  out  CHANNELS  1-cycle pulse when a timed note expires.
- cmd_err  out  1  1-cycle pulse when note_ch ≥ CHANNELS.

## Operation
- **Reset values:** all outputs are 0, all counters are 0, all voices are idle. note_ready is 0 during reset and 1 from the first clk edge after rst_n rises.
- **Handshake:**
  - A command is accepted on an edge where note_valid and note_ready are both 1.
  - note_ready stays 1 outside reset; there is no back-pressure.
  - A command with note_ch ≥ CHANNELS is accepted and dropped, and cmd_err pulses.
- **Millisecond prescaler:**
  - One free-running prescaler is shared by all voices. It counts 0..TICKS_PER_MS-1.
  - ms_tick is high on the cycle the count equals TICKS_PER_MS-1.
  - The prescaler is not restarted by commands, so actual duration lies in (dur-1, dur] ms.
- **Load, period ≠ 0:**
  - Sets phase counter = 0, sound[ch] = 0, dur_cnt = note_dur, busy = 1.
  - A load on a busy voice retriggers it and produces no done pulse.
- **Stop, period = 0:** busy = 0, sound[ch] = 0, no done pulse.
- **Tone generation:**
  - While busy, the phase counter increments each cycle.
  - When it equals period-1, the counter returns to 0 and sound[ch] toggles.
  - Output frequency = f_clk / (2·period). period = 1 toggles every cycle.
- **Duration:**
  - On ms_tick, with busy = 1 and dur_cnt ≠ 0, dur_cnt decrements.
  - A decrement from 1 to 0 clears busy and sound[ch] and pulses done[ch], all on the same edge.
  - dur_cnt = 0 at load means sustain: the voice never expires.
- **Simultaneous events:** if a load targets a voice on the same edge it would expire, the load wins and no done pulse is produced.
- **Mixer:**
  - n = popcount(sound), width MW = clog2(CHANNELS+1).
  - Accumulator acc is MW+1 bits. s = acc + n.
  - sound_mix = (s ≥ CHANNELS), registered. acc ← s − (sound_mix_next ? CHANNELS : 0).
  - Long-run density of sound_mix = n / CHANNELS.
- **Reset mid-note:** asserting rst_n low clears everything immediately and asynchronously. No done pulse is produced.

## Timing
- Command accepted at edge k: busy is 1 after k, and the first sound toggle occurs at edge k+period.
- After the first toggle, the square wave has period 2·period cycles.
- done, busy fall and sound clear coincide on the edge after the last ms_tick cycle.
- sound_mix lags sound by 1 cycle.
- cmd_err pulses on the accept edge.

## Structure
- Shared package holds:
  - the note command struct {ch, period, dur};
  - constants MAX_CHANNELS = 8 and the default TICKS_PER_MS = 10;
  - a function computing the mixer width.
- Sub-module `tone_voice`: phase counter, duration counter, toggle, busy and done logic for one voice. It is instantiated CHANNELS times with a generate loop.
- The top level holds the prescaler, command decode and the mixer.

## Test plan
- Defaults (CHANNELS = 2, TICKS_PER_MS = 10).
- **Single timed note:**
  - Stimulus: ch 0, period 3, dur 2.
  - Required: sound[0] toggles every 3 cycles; first toggle 3 edges after accept.
  - Required: busy[0] stays high 11..20 cycles, then done[0] pulses once and sound[0] = 0.
- **Sustain and stop:**
  - Stimulus: ch 1, period 5, dur 0; run 500 cycles; then send ch 1, period 0.
  - Required: busy[1] stays 1 and the 10-cycle square wave continues throughout; the stop clears busy[1] and sound[1] on the next edge with done[1] = 0.
- **Retrigger on expiry edge:**
  - Stimulus: ch 0, dur 1, then reload ch 0 on its expiry cycle.
  - Required: no done pulse; busy[0] stays 1; phase restarts.
- **Invalid channel:**
  - Stimulus: note_ch = 5.
  - Required: cmd_err pulses once; busy unchanged.
- **Mixer density:**
  - Stimulus: both voices sustained, period 1 on each, with voice 1 loaded one cycle after voice 0.
  - Required: n = 1 constantly; sound_mix alternates 0/1 (density exactly 50%).
- **Async reset:**
  - Stimulus: pull rst_n low mid-note between clk edges.
  - Required: all outputs are 0 immediately; no done pulse after release.
